one_bit_adder: RTL and testbench

ONE_BIT_ADDER -- requirements
Module: one_bit_adder

---
 rtl/one_bit_adder_pkg.sv | 9 +
 rtl/one_bit_adder_half_adder.sv | 12 +
 rtl/one_bit_adder.sv | 93 +++++++++
 tb/tb_one_bit_adder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/one_bit_adder_pkg.sv
// Shared configuration for one_bit_adder: carry-counter width defaults and legal bounds.
package one_bit_adder_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int CNT_SAT_DEF = 1;
    localparam int CNT_W_MIN   = 2;
    localparam int CNT_W_MAX   = 32;

endpackage

// File: rtl/one_bit_adder_half_adder.sv
// Half adder: sum = x ^ y, carry = x & y. Two of these form the full-adder core.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    assign sum   = x ^ y;
    assign carry = x & y;

endmodule

// File: rtl/one_bit_adder.sv
// Full adder with generate/propagate and an optional registered stage plus carry-event counter.
// The registered stage is built only when ONE_BIT_ADDER_REG_EN is defined; otherwise it is a pass-through.
module one_bit_adder
    import one_bit_adder_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int CNT_SAT = CNT_SAT_DEF
) (
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             sum,
    output logic             cout,
    input  logic             clk,
    input  logic             rst,
    output logic             g,
    output logic             p,
    input  logic             en,
    output logic             sum_q,
    output logic             cout_q,
    output logic [CNT_W-1:0] carry_cnt
);

    logic c_mid;

    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("one_bit_adder: CNT_W out of range");
    end
    if (CNT_SAT != 0 && CNT_SAT != 1) begin : g_bad_cnt_sat
        $error("one_bit_adder: CNT_SAT must be 0 or 1");
    end

    // The first half adder's outputs are exactly propagate and generate.
    half_adder u_ha0 (
        .x     (a),
        .y     (b),
        .sum   (p),
        .carry (g)
    );

    half_adder u_ha1 (
        .x     (p),
        .y     (cin),
        .sum   (sum),
        .carry (c_mid)
    );

    assign cout = g | c_mid;

`ifdef ONE_BIT_ADDER_REG_EN

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sum_r;
    logic             cout_r;
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r  <= 1'b0;
            cout_r <= 1'b0;
            cnt_r  <= '0;
        end else if (en) begin
            sum_r  <= sum;
            cout_r <= cout;
            if (cout) begin
                if (cnt_r == CNT_MAX) begin
                    cnt_r <= (CNT_SAT != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign sum_q     = sum_r;
    assign cout_q    = cout_r;
    assign carry_cnt = cnt_r;

`else

    // No state in this build; clock, reset and enable are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en};

    assign sum_q     = sum;
    assign cout_q    = cout;
    assign carry_cnt = '0;

`endif

endmodule

// File: tb/tb_one_bit_adder.sv
// Self-checking bench for one_bit_adder; expectations follow ONE_BIT_ADDER_REG_EN when defined.
module tb_one_bit_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b, cin, en;
  logic       sum, cout, g, p, sum_q, cout_q;
  logic [7:0] carry_cnt;
  logic       w_sum, w_cout, w_g, w_p, w_sum_q, w_cout_q;
  logic [7:0] w_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [3:0] exp_q[$];

  // reference state for the registered outputs
  logic       m_sq = 1'b0;
  logic       m_cq = 1'b0;
  logic [7:0] m_cs = 8'd0;
  logic [7:0] m_cw = 8'd0;

  bit clk_run = 1'b0;

  one_bit_adder #(.CNT_W(8), .CNT_SAT(1)) dut (
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .clk(clk), .rst(rst), .g(g), .p(p), .en(en),
    .sum_q(sum_q), .cout_q(cout_q), .carry_cnt(carry_cnt)
  );

  one_bit_adder #(.CNT_W(8), .CNT_SAT(0)) dut_wrap (
    .a(a), .b(b), .cin(cin), .sum(w_sum), .cout(w_cout),
    .clk(clk), .rst(rst), .g(w_g), .p(w_p), .en(en),
    .sum_q(w_sum_q), .cout_q(w_cout_q), .carry_cnt(w_cnt)
  );

  // clock / reset block
  initial begin
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic maj(input logic ai, input logic bi, input logic ci);
    logic [1:0] tot;
    tot = 2'(ai) + 2'(bi) + 2'(ci);
    return tot[1];
  endfunction

  // driver: apply inputs, push expected {sum,cout,g,p}, then pop and compare
  task automatic drive(input logic ai, input logic bi, input logic ci, input string tag);
    logic [1:0] tot;
    logic [3:0] e;
    a   = ai;
    b   = bi;
    cin = ci;
    tot = 2'(ai) + 2'(bi) + 2'(ci);
    exp_q.push_back({tot[0], tot[1], ai & bi, ai ^ bi});
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"},  {31'd0, sum},    {31'd0, e[3]});
      check({tag, "_cout"}, {31'd0, cout},   {31'd0, e[2]});
      check({tag, "_g"},    {31'd0, g},      {31'd0, e[1]});
      check({tag, "_p"},    {31'd0, p},      {31'd0, e[0]});
      check({tag, "_wsum"}, {31'd0, w_sum},  {31'd0, e[3]});
      check({tag, "_wcout"},{31'd0, w_cout}, {31'd0, e[2]});
    end
  endtask

  task automatic model_reset();
    m_sq = 1'b0;
    m_cq = 1'b0;
    m_cs = 8'd0;
    m_cw = 8'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (en) begin
      m_sq = a ^ b ^ cin;
      m_cq = maj(a, b, cin);
      if (m_cq) begin
        m_cs = (m_cs == 8'hff) ? 8'hff : m_cs + 8'd1;
        m_cw = m_cw + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_regs(input string tag);
`ifdef ONE_BIT_ADDER_REG_EN
    check({tag, "_sum_q"},  {31'd0, sum_q},    {31'd0, m_sq});
    check({tag, "_cout_q"}, {31'd0, cout_q},   {31'd0, m_cq});
    check({tag, "_cnt"},    {24'd0, carry_cnt},{24'd0, m_cs});
    check({tag, "_wcnt"},   {24'd0, w_cnt},    {24'd0, m_cw});
`else
    check({tag, "_sum_q"},  {31'd0, sum_q},    {31'd0, a ^ b ^ cin});
    check({tag, "_cout_q"}, {31'd0, cout_q},   {31'd0, maj(a, b, cin)});
    check({tag, "_cnt"},    {24'd0, carry_cnt},32'd0);
    check({tag, "_wcnt"},   {24'd0, w_cnt},    32'd0);
`endif
  endtask

  initial begin
    logic [7:0] sum_tab;
    logic [7:0] cout_tab;
    logic [2:0] v;
    sum_tab  = 8'b1001_0110;
    cout_tab = 8'b1110_1000;

    rst = 1'b1;
    en  = 1'b0;
    a   = 1'b0;
    b   = 1'b0;
    cin = 1'b0;
    #1;
    check_regs("reset");
    rst = 1'b0;
    #1;

    // exhaustive truth table with the clock idle
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[1], v[0], v[2], "tt");
      check("tt_tab_sum",  {31'd0, sum},  {31'd0, sum_tab[i]});
      check("tt_tab_cout", {31'd0, cout}, {31'd0, cout_tab[i]});
    end
    check_regs("tt_regs");

    // generate case: g/p immediate, registered result after one edge
    en = 1'b1;
    drive(1'b1, 1'b1, 1'b0, "gen");
    check("gen_g", {31'd0, g}, 32'd1);
    check("gen_p", {31'd0, p}, 32'd0);
`ifndef ONE_BIT_ADDER_REG_EN
    check("gen_pass_sum_q",  {31'd0, sum_q},    32'd0);
    check("gen_pass_cout_q", {31'd0, cout_q},   32'd1);
    check("gen_pass_cnt",    {24'd0, carry_cnt},32'd0);
`else
    check("gen_pre_cout_q",  {31'd0, cout_q},   32'd0);
`endif
    clk_run = 1'b1;
    tick();
    check_regs("gen_edge");
    check("gen_sum_q",  {31'd0, sum_q},  32'd0);
    check("gen_cout_q", {31'd0, cout_q}, 32'd1);
    repeat (4) tick();
    check_regs("cnt5");
`ifdef ONE_BIT_ADDER_REG_EN
    check("cnt5_const", {24'd0, carry_cnt}, 32'd5);
`endif

    // asynchronous reset between edges; combinational outputs keep tracking
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("rst_async");
    drive(1'b0, 1'b1, 1'b1, "rst_trk0");
    drive(1'b1, 1'b0, 1'b0, "rst_trk1");
    check_regs("rst_hold");
    rst = 1'b0;

    // reset held across an edge overrides en; first update after release
    drive(1'b1, 1'b1, 1'b1, "ovr");
    tick();
    check_regs("ovr_pre");
    rst = 1'b1;
    tick();
    check_regs("ovr_rst_edge");
    rst = 1'b0;
    tick();
    check_regs("ovr_release");

    // en low: random inputs must not disturb registered state
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 3'($urandom_range(0, 7));
      drive(v[1], v[0], v[2], "hold");
      tick();
      check_regs("hold");
    end
    a = 1'bx;
    tick();
`ifdef ONE_BIT_ADDER_REG_EN
    check_regs("hold_x");
`endif
    a = 1'b0;
    #1;

    // counter boundary: 300 carry edges, saturating and wrapping instances
    rst = 1'b1;
    #1;
    model_reset();
    rst = 1'b0;
    en  = 1'b1;
    drive(1'b1, 1'b1, 1'b0, "cnt");
    repeat (255) tick();
    check_regs("cnt255");
    tick();
    check_regs("cnt256");
`ifdef ONE_BIT_ADDER_REG_EN
    check("cnt256_sat",  {24'd0, carry_cnt}, 32'd255);
    check("cnt256_wrap", {24'd0, w_cnt},     32'd0);
`endif
    repeat (44) tick();
    check_regs("cnt300");
`ifdef ONE_BIT_ADDER_REG_EN
    check("cnt300_sat",  {24'd0, carry_cnt}, 32'd255);
    check("cnt300_wrap", {24'd0, w_cnt},     32'd44);
`else
    check("cnt300_tied", {24'd0, carry_cnt}, 32'd0);
`endif

    clk_run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
